// File: rtl/l2_line_adaptor.sv
// l2_line_adaptor: bridges a 256-bit cache-line request interface (l2_control)
// to a 64-bit, 4-beat burst physical memory interface.
//
// Ports:
//   clk, rst            - clock (rising edge) and asynchronous active-high reset
//   cacheline_read      - line fill request
//   cacheline_write     - line writeback request
//   cacheline_address   - line address, bits [4:0] ignored
//   cacheline_wdata     - line to write back
//   cacheline_rdata     - filled line (registered, held until next fill)
//   cacheline_resp      - one-cycle completion pulse
//   pmem_read/write     - burst request, high for the whole burst
//   pmem_address        - line-aligned burst address, 0 when not bursting
//   pmem_wdata          - current write beat
//   pmem_rdata          - current read beat
//   pmem_resp           - beat valid
//   err (optional)      - sticky protocol error, present only when the macro
//                         L2_LINE_ADAPTOR_ERR_EN is defined
module l2_line_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic         cacheline_read,
    input  logic         cacheline_write,
    input  logic [31:0]  cacheline_address,
    input  logic [255:0] cacheline_wdata,
    output logic [255:0] cacheline_rdata,
    output logic         cacheline_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [63:0]  pmem_wdata,
    input  logic [63:0]  pmem_rdata,
    input  logic         pmem_resp
`ifdef L2_LINE_ADAPTOR_ERR_EN
    ,
    output logic         err
`endif
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e         state_q;
    logic [1:0]     beat_q;
    logic [26:0]    addr_q;
    logic [255:0]   wdata_q;
    logic [255:0]   rdata_q;

    logic           busy;
    logic [7:0]     beat_base;

    assign busy      = (state_q == StRead) || (state_q == StWrite);
    assign beat_base = {beat_q, 6'd0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Simultaneous read and write is a protocol violation: accept neither.
                    if (cacheline_read && !cacheline_write) begin
                        state_q <= StRead;
                        beat_q  <= 2'd0;
                        addr_q  <= cacheline_address[31:5];
                    end else if (cacheline_write && !cacheline_read) begin
                        state_q <= StWrite;
                        beat_q  <= 2'd0;
                        addr_q  <= cacheline_address[31:5];
                        wdata_q <= cacheline_wdata;
                    end
                end
                StRead: begin
                    if (pmem_resp) begin
                        rdata_q[beat_base +: 64] <= pmem_rdata;
                        beat_q                   <= beat_q + 2'd1;
                        if (beat_q == 2'd3) state_q <= StDone;
                    end
                end
                StWrite: begin
                    if (pmem_resp) begin
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd3) state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cacheline_rdata = rdata_q;
    assign cacheline_resp  = (state_q == StDone);
    assign pmem_read       = (state_q == StRead);
    assign pmem_write      = (state_q == StWrite);
    assign pmem_address    = busy ? {addr_q, 5'd0} : 32'd0;
    assign pmem_wdata      = wdata_q[beat_base +: 64];

`ifdef L2_LINE_ADAPTOR_ERR_EN
    logic err_q;

    // Beats after the first must arrive on consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (((state_q == StIdle) && cacheline_read && cacheline_write) ||
                     (busy && (beat_q != 2'd0) && !pmem_resp)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_l2_line_adaptor.sv
module tb_l2_line_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cacheline_read = 1'b0;
    logic         cacheline_write = 1'b0;
    logic [31:0]  cacheline_address = '0;
    logic [255:0] cacheline_wdata = '0;
    logic [255:0] cacheline_rdata;
    logic         cacheline_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
`ifdef L2_LINE_ADAPTOR_ERR_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;

    // Model: the line last delivered by a completed fill (0 after reset).
    logic [255:0] last_line = '0;

    always #5 clk = ~clk;

    l2_line_adaptor dut (
        .clk               (clk),
        .rst               (rst),
        .cacheline_read    (cacheline_read),
        .cacheline_write   (cacheline_write),
        .cacheline_address (cacheline_address),
        .cacheline_wdata   (cacheline_wdata),
        .cacheline_rdata   (cacheline_rdata),
        .cacheline_resp    (cacheline_resp),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_rdata        (pmem_rdata),
        .pmem_resp         (pmem_resp)
`ifdef L2_LINE_ADAPTOR_ERR_EN
        ,
        .err               (err)
`endif
    );

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cacheline_resp, pmem_read, pmem_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000", {cacheline_resp, pmem_read, pmem_write});
        end
        checks++;
        if (pmem_address !== 32'd0 || pmem_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_bus addr %h wdata %h want 0", pmem_address, pmem_wdata);
        end
        checks++;
        if (cacheline_rdata !== 256'd0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", cacheline_rdata);
        end
`ifdef L2_LINE_ADAPTOR_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", err);
        end
`endif
        rst = 1'b0;
        last_line = '0;
        @(negedge clk);
    endtask

    // One fill: first beat offered k cycles after acceptance. With hold the
    // request stays high until the completion cycle, as l2_control does.
    task automatic run_read(input logic [31:0] addr, input logic [255:0] line,
                            input int k, input bit hold);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:5], 5'd0};
        pmem_resp = 1'b0;
        cacheline_read = 1'b1;
        cacheline_write = 1'b0;
        cacheline_address = addr;
        @(negedge clk);
        if (!hold) cacheline_read = 1'b0;
        for (int c = 0; c < k; c++) begin
            checks++;
            if (pmem_read !== 1'b1 || pmem_address !== exp_addr || cacheline_resp !== 1'b0) begin
                errors++;
                $display("FAIL read_wait rd %b addr %h resp %b want 1 %h 0",
                         pmem_read, pmem_address, cacheline_resp, exp_addr);
            end
            cacheline_address = $urandom;
            cacheline_wdata = rand_line();
            @(negedge clk);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== exp_addr ||
                cacheline_resp !== 1'b0) begin
                errors++;
                $display("FAIL read_beat%0d rd %b wr %b addr %h resp %b want 1 0 %h 0",
                         b, pmem_read, pmem_write, pmem_address, cacheline_resp, exp_addr);
            end
            pmem_resp = 1'b1;
            pmem_rdata = line[64*b +: 64];
            cacheline_address = $urandom;
            @(negedge clk);
        end
        // Completion cycle; stray pmem_resp here must be ignored.
        pmem_resp = $urandom_range(0, 1);
        pmem_rdata = rand64();
        checks++;
        if (cacheline_resp !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'd0) begin
            errors++;
            $display("FAIL read_done resp %b rd %b addr %h want 1 0 0",
                     cacheline_resp, pmem_read, pmem_address);
        end
        checks++;
        if (cacheline_rdata !== line) begin
            errors++;
            $display("FAIL read_data got %h want %h", cacheline_rdata, line);
        end
        last_line = line;
        cacheline_read = 1'b0;
        @(negedge clk);
        pmem_resp = $urandom_range(0, 1);
        checks++;
        if (cacheline_resp !== 1'b0 || pmem_read !== 1'b0 || cacheline_rdata !== line) begin
            errors++;
            $display("FAIL read_after resp %b rd %b data %h want 0 0 %h",
                     cacheline_resp, pmem_read, cacheline_rdata, line);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || cacheline_resp !== 1'b0) begin
            errors++;
            $display("FAIL read_single rd %b wr %b resp %b want 0 0 0",
                     pmem_read, pmem_write, cacheline_resp);
        end
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                             input int k, input bit hold);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:5], 5'd0};
        pmem_resp = 1'b0;
        cacheline_write = 1'b1;
        cacheline_read = 1'b0;
        cacheline_address = addr;
        cacheline_wdata = line;
        @(negedge clk);
        if (!hold) cacheline_write = 1'b0;
        for (int c = 0; c < k; c++) begin
            checks++;
            if (pmem_write !== 1'b1 || pmem_address !== exp_addr || pmem_wdata !== line[63:0]) begin
                errors++;
                $display("FAIL write_wait wr %b addr %h wdata %h want 1 %h %h",
                         pmem_write, pmem_address, pmem_wdata, exp_addr, line[63:0]);
            end
            cacheline_address = $urandom;
            cacheline_wdata = rand_line();
            @(negedge clk);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== exp_addr ||
                pmem_wdata !== line[64*b +: 64] || cacheline_resp !== 1'b0) begin
                errors++;
                $display("FAIL write_beat%0d wr %b rd %b addr %h wdata %h resp %b want 1 0 %h %h 0",
                         b, pmem_write, pmem_read, pmem_address, pmem_wdata, cacheline_resp,
                         exp_addr, line[64*b +: 64]);
            end
            pmem_resp = 1'b1;
            cacheline_address = $urandom;
            cacheline_wdata = rand_line();
            @(negedge clk);
        end
        pmem_resp = $urandom_range(0, 1);
        checks++;
        if (cacheline_resp !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'd0) begin
            errors++;
            $display("FAIL write_done resp %b wr %b addr %h want 1 0 0",
                     cacheline_resp, pmem_write, pmem_address);
        end
        checks++;
        if (cacheline_rdata !== last_line) begin
            errors++;
            $display("FAIL rdata_hold got %h want %h", cacheline_rdata, last_line);
        end
        cacheline_write = 1'b0;
        @(negedge clk);
        pmem_resp = $urandom_range(0, 1);
        checks++;
        if (cacheline_resp !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL write_after resp %b wr %b want 0 0", cacheline_resp, pmem_write);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || cacheline_resp !== 1'b0) begin
            errors++;
            $display("FAIL write_single rd %b wr %b resp %b want 0 0 0",
                     pmem_read, pmem_write, cacheline_resp);
        end
    endtask

    task automatic test_read_fixed();
        logic [255:0] line;
        line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run_read(32'h0000_1234, line, 2, 1'b0);
    endtask

    task automatic test_write_fixed();
        run_write(32'hFFFF_FFE7, {64'hD, 64'hC, 64'hB, 64'hA}, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1)
                run_read($urandom, rand_line(), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
            else
                run_write($urandom, rand_line(), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_conflict();
`ifdef L2_LINE_ADAPTOR_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean got %b want 0", err);
        end
`endif
        cacheline_read = 1'b1;
        cacheline_write = 1'b1;
        cacheline_address = $urandom;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({pmem_read, pmem_write, cacheline_resp} !== 3'b000 || pmem_address !== 32'd0) begin
                errors++;
                $display("FAIL conflict rd/wr/resp %b addr %h want 000 0",
                         {pmem_read, pmem_write, cacheline_resp}, pmem_address);
            end
`ifdef L2_LINE_ADAPTOR_ERR_EN
            checks++;
            if (err !== 1'b1) begin
                errors++;
                $display("FAIL conflict_err got %b want 1", err);
            end
`endif
        end
        cacheline_read = 1'b0;
        cacheline_write = 1'b0;
        @(negedge clk);
        test_reset();
    endtask

    task automatic test_reset_mid();
        logic [255:0] line;
        line = rand_line();
        pmem_resp = 1'b0;
        cacheline_read = 1'b1;
        cacheline_address = $urandom;
        @(negedge clk);
        cacheline_read = 1'b0;
        for (int b = 0; b < 2; b++) begin
            pmem_resp = 1'b1;
            pmem_rdata = line[64*b +: 64];
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cacheline_resp, pmem_read, pmem_write} !== 3'b000 || pmem_address !== 32'd0 ||
            pmem_wdata !== 64'd0 || cacheline_rdata !== 256'd0) begin
            errors++;
            $display("FAIL reset_async resp/rd/wr %b addr %h wdata %h rdata %h want 000 0 0 0",
                     {cacheline_resp, pmem_read, pmem_write}, pmem_address, pmem_wdata,
                     cacheline_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        last_line = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({cacheline_resp, pmem_read, pmem_write} !== 3'b000) begin
                errors++;
                $display("FAIL reset_abort resp/rd/wr %b want 000",
                         {cacheline_resp, pmem_read, pmem_write});
            end
        end
        run_read($urandom, rand_line(), 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_write($urandom, rand_line(), 0, 1'b1);
        run_read($urandom, rand_line(), 1, 1'b1);
        run_write($urandom, rand_line(), 2, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_fixed();
        test_write_fixed();
        test_conflict();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef L2_LINE_ADAPTOR_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_spurious got %b want 0", err);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
